// File: rtl/pc_fetch_ctrl.sv
// Program-counter owner and single-outstanding instruction-fetch sequencer.
// Build macro PC_MISALIGN_TRAP_EN: misaligned jumps go to TRAP_VEC and pulse misalign.
//
// state | meaning
// IDLE  | first cycle after reset release
// REQ   | fetch request presented at pc
// WAIT  | request granted, awaiting response
// HOLD  | fetched instruction presented to decode
module pc_fetch_ctrl #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
    parameter int                PC_INC   = 4
`ifdef PC_MISALIGN_TRAP_EN
    ,
    parameter logic [ADDR_W-1:0] TRAP_VEC = 8'h10
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] pc,
    output logic              misalign
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] pc_d, req_pc, req_pc_d, inst_pc_d, jump_tgt;
    logic [DATA_W-1:0] inst_data_d;
    logic              kill, kill_d, inst_valid_d;

`ifdef PC_MISALIGN_TRAP_EN
    logic jump_mis;
    assign jump_mis = |jump_addr[1:0];
    assign jump_tgt = jump_mis ? TRAP_VEC : jump_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign <= 1'b0;
        else        misalign <= jump_valid && jump_mis;
    end
`else
    assign jump_tgt = jump_addr & ~ADDR_W'(3);
    assign misalign = 1'b0;
`endif

    assign imem_req  = (state == REQ);
    assign imem_addr = pc;

    always_comb begin
        state_d      = state;
        pc_d         = pc;
        req_pc_d     = req_pc;
        kill_d       = kill;
        inst_valid_d = inst_valid;
        inst_data_d  = inst_data;
        inst_pc_d    = inst_pc;
        case (state)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_gnt) begin
                    req_pc_d = pc;
                    kill_d   = jump_valid;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    kill_d  = 1'b0;
                    state_d = REQ;
                    if (!kill && !jump_valid) begin
                        inst_data_d  = imem_rdata;
                        inst_pc_d    = req_pc;
                        inst_valid_d = 1'b1;
                        pc_d         = pc + ADDR_W'(PC_INC);
                        state_d      = HOLD;
                    end
                end else if (jump_valid) begin
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                // A redirect flushes the held instruction even if decode is ready.
                if (jump_valid || inst_ready) begin
                    inst_valid_d = 1'b0;
                    state_d      = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
        if (jump_valid) pc_d = jump_tgt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            req_pc     <= '0;
            kill       <= 1'b0;
            inst_valid <= 1'b0;
            inst_data  <= '0;
            inst_pc    <= '0;
        end else begin
            state      <= state_d;
            pc         <= pc_d;
            req_pc     <= req_pc_d;
            kill       <= kill_d;
            inst_valid <= inst_valid_d;
            inst_data  <= inst_data_d;
            inst_pc    <= inst_pc_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: random memory/decode/jump stimulus against a program-order model.
module tb_pc_fetch_ctrl;

    localparam logic [7:0] RESET_PC = 8'h00;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        jump_valid = 1'b0, imem_gnt = 1'b0, imem_rvalid = 1'b0, inst_ready = 1'b0;
    logic [7:0]  jump_addr = '0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req, inst_valid, misalign;
    logic [7:0]  imem_addr, inst_pc, pc;
    logic [31:0] inst_data;

    pc_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .jump_valid(jump_valid), .jump_addr(jump_addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
        .pc(pc), .misalign(misalign)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int gnt_pct = 100, dly_min = 0, dly_max = 0, ready_pct = 100, spur_pct = 0;
    int delivered = 0, vcount = 0;

    // program-order model and memory model
    logic [7:0]  exp_pc;
    bit          mem_busy = 0;
    logic [7:0]  mem_addr;
    int          mem_dly;
    logic [7:0]  deliv_q[$], grant_q[$];
    bit          p_stall, p_flush, p_jump, p_mis;
    logic [31:0] p_data;
    logic [7:0]  p_ipc, p_tgt;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [7:0] a);
        return {a, a ^ 8'h5A, ~a, 8'hC3};
    endfunction

    function automatic logic [7:0] tgt(input logic [7:0] a);
`ifdef PC_MISALIGN_TRAP_EN
        return (a % 4 != 0) ? 8'h10 : a;
`else
        return a & 8'hFC;
`endif
    endfunction

    function automatic bit mis(input logic [7:0] a);
`ifdef PC_MISALIGN_TRAP_EN
        return (a % 4 != 0);
`else
        return (a === 8'hzz);
`endif
    endfunction

    function automatic logic [7:0] q_at(input logic [7:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 8'hxx;
    endfunction

    task automatic step(input bit do_jump, input logic [7:0] ja);
        bit resp;
        @(negedge clk);
        if (p_stall) begin
            check_eq("stall_valid", inst_valid, 1);
            check_eq("stall_data", inst_data, p_data);
            check_eq("stall_pc", inst_pc, p_ipc);
        end
        if (p_flush) check_eq("flush_valid", inst_valid, 0);
        if (p_jump) check_eq("jump_pc", pc, p_tgt);
        check_eq("misalign", misalign, p_mis);
        check_eq("req_and_valid", imem_req & inst_valid, 0);
        if (inst_valid) vcount++;

        jump_valid  = do_jump;
        jump_addr   = do_jump ? ja : 8'($urandom);
        inst_ready  = ($urandom_range(99) < ready_pct);
        resp        = mem_busy && (mem_dly == 0);
        imem_rvalid = resp || (!mem_busy && ($urandom_range(99) < spur_pct));
        imem_rdata  = resp ? memf(mem_addr) : $urandom;
        imem_gnt    = imem_req && !mem_busy && ($urandom_range(99) < gnt_pct);
        if (mem_busy) begin
            if (resp) mem_busy = 0;
            else      mem_dly--;
        end
        if (imem_gnt) begin
            mem_busy = 1;
            mem_addr = imem_addr;
            mem_dly  = $urandom_range(dly_max, dly_min);
        end

        if (do_jump) begin
            exp_pc = tgt(ja);
            deliv_q.delete();
            grant_q.delete();
        end else begin
            if (inst_valid && inst_ready) begin
                check_eq("deliver_pc", inst_pc, exp_pc);
                check_eq("deliver_data", inst_data, memf(exp_pc));
                deliv_q.push_back(inst_pc);
                exp_pc = exp_pc + 8'd4;
                delivered++;
            end
            if (imem_gnt) begin
                check_eq("fetch_addr", imem_addr, exp_pc);
                grant_q.push_back(imem_addr);
            end
        end
        p_stall = inst_valid && !inst_ready && !do_jump;
        p_data  = inst_data;
        p_ipc   = inst_pc;
        p_flush = inst_valid && do_jump;
        p_jump  = do_jump;
        p_tgt   = tgt(ja);
        p_mis   = do_jump && mis(ja);
    endtask

    task automatic reset_dut(input bit keep_mem);
        rst_n = 1'b0;
        jump_valid = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_req", imem_req, 0);
        check_eq("rst_valid", inst_valid, 0);
        check_eq("rst_data", inst_data, 0);
        check_eq("rst_ipc", inst_pc, 0);
        check_eq("rst_pc", pc, RESET_PC);
        check_eq("rst_misalign", misalign, 0);
        rst_n = 1'b1;
        exp_pc = RESET_PC;
        {p_stall, p_flush, p_jump, p_mis} = '0;
        deliv_q.delete();
        grant_q.delete();
        if (keep_mem) mem_dly = 0;
        else          mem_busy = 0;
    endtask

    task automatic run(input int n);
        repeat (n) step(0, 8'h00);
    endtask

    initial begin
        int n;
        logic [31:0] hd;
        logic [7:0]  hp;

        // back-to-back fetch from reset
        reset_dut(0);
        vcount = 0;
        run(9);
        check_eq("t1_valid_count", vcount, 3);
        check_eq("t1_grant0", q_at(grant_q, 0), 8'h00);
        check_eq("t1_grant1", q_at(grant_q, 1), 8'h04);
        check_eq("t1_grant2", q_at(grant_q, 2), 8'h08);
        check_eq("t1_deliv0", q_at(deliv_q, 0), 8'h00);
        check_eq("t1_deliv1", q_at(deliv_q, 1), 8'h04);
        check_eq("t1_deliv2", q_at(deliv_q, 2), 8'h08);

        // wrap from FC
        n = 0;
        while (!imem_req && n < 20) begin step(0, 8'h00); n++; end
        check_eq("t2_reach", n < 20, 1);
        step(1, 8'hFC);
        run(8);
        check_eq("t2_deliv_fc", q_at(deliv_q, 0), 8'hFC);
        check_eq("t2_grant_wrap", q_at(grant_q, 1), 8'h00);
        check_eq("t2_deliv_wrap", q_at(deliv_q, 1), 8'h00);

        // redirect while waiting on the fetch of 08
        dly_min = 2; dly_max = 2;
        n = 0;
        while (!(mem_busy && mem_addr == 8'h08) && n < 40) begin step(0, 8'h00); n++; end
        check_eq("t3_reach", n < 40, 1);
        step(1, 8'h40);
        run(12);
        check_eq("t3_grant", q_at(grant_q, 0), 8'h40);
        check_eq("t3_deliv", q_at(deliv_q, 0), 8'h40);

        // redirect in HOLD with decode ready
        dly_min = 0; dly_max = 0;
        n = 0;
        while (!inst_valid && n < 20) begin step(0, 8'h00); n++; end
        check_eq("t4_reach", n < 20, 1);
        step(1, 8'h80);
        step(0, 8'h00);
        check_eq("t4_flush", inst_valid, 0);
        run(8);
        check_eq("t4_grant", q_at(grant_q, 0), 8'h80);
        check_eq("t4_deliv", q_at(deliv_q, 0), 8'h80);

        // decode stall in HOLD
        ready_pct = 0;
        n = 0;
        while (!inst_valid && n < 20) begin step(0, 8'h00); n++; end
        check_eq("t5_reach", n < 20, 1);
        hd = inst_data;
        hp = inst_pc;
        repeat (5) begin
            step(0, 8'h00);
            check_eq("t5_valid", inst_valid, 1);
            check_eq("t5_data", inst_data, hd);
            check_eq("t5_ipc", inst_pc, hp);
            check_eq("t5_noreq", imem_req, 0);
            check_eq("t5_pc", pc, hp + 8'd4);
        end
        ready_pct = 100;

        // reset during WAIT, late response after release
        dly_min = 3; dly_max = 3;
        n = 0;
        while (!mem_busy && n < 20) begin step(0, 8'h00); n++; end
        check_eq("t6_reach", n < 20, 1);
        step(0, 8'h00);
        reset_dut(1);
        dly_min = 0; dly_max = 0;
        run(8);
        check_eq("t6_grant", q_at(grant_q, 0), RESET_PC);
        check_eq("t6_deliv", q_at(deliv_q, 0), RESET_PC);

`ifdef PC_MISALIGN_TRAP_EN
        step(1, 8'h42);
        step(0, 8'h00);
        check_eq("t7_trap_pc", pc, 8'h10);
        check_eq("t7_mis_hi", misalign, 1);
        step(0, 8'h00);
        check_eq("t7_mis_lo", misalign, 0);
`endif

        // randomized traffic
        gnt_pct = 60; dly_min = 0; dly_max = 3; ready_pct = 60; spur_pct = 20;
        delivered = 0;
        repeat (3000) begin
            if ($urandom_range(99) < 6) step(1, 8'($urandom));
            else                        step(0, 8'h00);
        end
        check_eq("rand_progress", delivered > 50, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
